spi_slave: RTL and testbench

SPI responder (target) for the team's 8-bit SPI master. Matches the master's mode: CS active-low, SCK idles low, MSB first, MOSI sampled on SCK rising edge, MISO updated on SCK falling edge. All SPI pins are oversampled in the single system clock domain. Exposes a byte-wide parallel interface to the processor side: a TX load handshake and an RX strobe, with multi-byte frames per CS assertion.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave.sv | 117 +++++++++++
 tb/tb_spi_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder and its pin synchronisers.
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_TX_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    SPI_S_IDLE,
    SPI_S_LOAD,
    SPI_S_SHIFT
  } spi_slave_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detect on the
// synchronised value. RST_VAL sets the idle level so reset never fakes an edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 0, MSB first, oversampled in the clk domain.
// state       | meaning
// SPI_S_IDLE  | cs high, miso parked low, waiting for cs fall
// SPI_S_LOAD  | one cycle: pull first TX byte into the shifter
// SPI_S_SHIFT | frame in progress, sample on sck rise, shift on sck fall
module spi_slave
  import spi_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [SPI_WIDTH-1:0] TX_DEFAULT  = SPI_TX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [SPI_WIDTH-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_empty,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 active,
  output logic                 underrun,
  output logic                 frame_err
);
  logic sck_s_unused, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_slave_state_t     state;
  logic [SPI_WIDTH-1:0] tx_hold, tx_shift, rx_shift, reload_byte;
  logic [3:0]           bit_cnt;
  logic                 do_reload;

  // Reload happens at frame start and at every byte boundary (8th falling edge).
  always_comb begin
    reload_byte = tx_empty ? TX_DEFAULT : tx_hold;
    do_reload   = 1'b0;
    if (!cs_rise) begin
      if (state == SPI_S_LOAD) do_reload = 1'b1;
      if (state == SPI_S_SHIFT && sck_fall && bit_cnt == 4'd8) do_reload = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SPI_S_IDLE;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_empty  <= 1'b1;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      tx_hold   <= TX_DEFAULT;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
    end else begin
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise) begin
        state     <= SPI_S_IDLE;
        miso      <= 1'b0;
        bit_cnt   <= '0;
        frame_err <= (bit_cnt != 4'd0);
      end else begin
        case (state)
          SPI_S_IDLE: begin
            miso <= 1'b0;
            if (cs_fall) state <= SPI_S_LOAD;
          end
          SPI_S_LOAD: state <= SPI_S_SHIFT;
          SPI_S_SHIFT: begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[SPI_WIDTH-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rx_data  <= {rx_shift[SPI_WIDTH-2:0], mosi_s};
                rx_valid <= 1'b1;
              end
            end else if (sck_fall && bit_cnt != 4'd0 && bit_cnt != 4'd8) begin
              tx_shift <= {tx_shift[SPI_WIDTH-2:0], 1'b0};
              miso     <= tx_shift[SPI_WIDTH-2];
            end
          end
          default: state <= SPI_S_IDLE;
        endcase
      end
      if (do_reload) begin
        tx_shift <= reload_byte;
        miso     <= reload_byte[SPI_WIDTH-1];
        underrun <= tx_empty;
        tx_empty <= 1'b1;
        bit_cnt  <= '0;
      end
      // A load coinciding with a reload lands after it: old byte goes out, new one is held.
      if (tx_load) begin
        tx_hold  <= tx_data;
        tx_empty <= 1'b0;
      end
    end
  end

  assign active = ~cs_s;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bench acts as a mode-0 master, RX bytes checked via a scoreboard.
module tb_spi_slave;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst, sck, cs, mosi, miso, tx_load, tx_empty, rx_valid, active, underrun, frame_err;
  logic [7:0] tx_data, rx_data;

  spi_slave dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .rx_data(rx_data), .rx_valid(rx_valid), .active(active),
    .underrun(underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         vecs = 0, errs = 0;
  int         ur_cnt = 0, fe_cnt = 0, rxv_cnt = 0;
  logic [7:0] rxq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (underrun) ur_cnt++;
      if (frame_err) fe_cnt++;
      if (rx_valid) begin
        rxv_cnt++;
        if (rxq.size() != 0) chk("rx_data", rx_data, rxq.pop_front());
        else begin
          errs++;
          $error("FAIL rx_extra: observed %0h expected none", rx_data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic start_frame();
    cs = 1'b0;
    tick(HALF + 1);
  endtask

  task automatic end_frame();
    tick(HALF);
    cs = 1'b1;
    tick(6);
  endtask

  // Full byte; optional load mid-byte and optional load on the exact boundary-reload cycle.
  task automatic spi_byte(input logic [7:0] m, input logic mid_en, input logic [7:0] mid_d,
                          input logic bnd_en, input logic [7:0] bnd_d,
                          output logic [7:0] r, output int ur_snap);
    rxq.push_back(m);
    for (int i = 7; i >= 0; i--) begin
      mosi = m[i];
      tick(HALF);
      r[i] = miso;
      if (i == 4 && mid_en) load(mid_d);
      sck = 1'b1;
      tick(HALF);
      if (i == 0) ur_snap = ur_cnt;
      sck = 1'b0;
    end
    if (bnd_en) begin
      tick(2);
      tx_data = bnd_d;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
    end
  endtask

  task automatic spi_bits(input int n, input logic [7:0] m);
    for (int i = 0; i < n; i++) begin
      mosi = m[7-i];
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, miso, 1'b0);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_tx_empty"}, tx_empty, 1'b1);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_underrun"}, underrun, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  logic [7:0] r;
  int         s, u0, f0, r0;

  initial begin
    rst = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    tick(3);
    chk_reset_vals("reset");
    rst = 1'b1;
    tick(4);

    // single byte, holding loaded
    load(8'hA5);
    chk("t1_tx_empty_loaded", tx_empty, 1'b0);
    u0 = ur_cnt; r0 = rxv_cnt;
    start_frame();
    chk("t1_tx_empty_after_load", tx_empty, 1'b1);
    chk("t1_active", active, 1'b1);
    spi_byte(8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t1_miso_byte", r, 8'hA5);
    chk("t1_no_underrun", s - u0, 0);
    end_frame();
    chk("t1_rx_count", rxv_cnt - r0, 1);
    chk("t1_no_frame_err", fe_cnt, 0);
    chk("t1_inactive", active, 1'b0);
    chk("t1_miso_idle", miso, 1'b0);
    // trailing 8th fall is a byte boundary with an empty holding register
    chk("t1_trailing_underrun", ur_cnt - u0, 1);

    // two-byte frame, second byte loaded while shifting
    load(8'h12);
    start_frame();
    spi_byte(8'hF0, 1'b1, 8'h34, 1'b0, 8'h00, r, s);
    chk("t2_miso_byte0", r, 8'h12);
    spi_byte(8'h0F, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t2_miso_byte1", r, 8'h34);
    end_frame();
    chk("t2_rx_hold", rx_data, 8'h0F);

    // no load: default byte and underrun in LOAD
    u0 = ur_cnt;
    start_frame();
    chk("t3_underrun_in_load", ur_cnt - u0, 1);
    spi_byte(8'h55, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t3_miso_default", r, 8'hFF);
    chk("t3_underrun_once", s - u0, 1);
    end_frame();
    chk("t3_rx_hold", rx_data, 8'h55);

    // cs raised after 5 bits
    f0 = fe_cnt; r0 = rxv_cnt;
    start_frame();
    spi_bits(5, 8'hA0);
    tick(HALF);
    cs = 1'b1;
    tick(6);
    chk("t4_frame_err", fe_cnt - f0, 1);
    chk("t4_no_rx_valid", rxv_cnt - r0, 0);
    chk("t4_idle_inactive", active, 1'b0);
    chk("t4_idle_miso", miso, 1'b0);
    load(8'h81);
    start_frame();
    spi_byte(8'h7E, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t4_recover_miso", r, 8'h81);
    end_frame();
    chk("t4_no_more_frame_err", fe_cnt - f0, 1);
    chk("t4_rx_hold", rx_data, 8'h7E);

    // reset mid-byte
    start_frame();
    load(8'h5A);
    chk("t5_tx_empty_pre", tx_empty, 1'b0);
    spi_bits(3, 8'hE0);
    tick(2);
    rst = 1'b0;
    #1;
    chk_reset_vals("t5_midreset");
    cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    chk("t5_post_release_inactive", active, 1'b0);
    load(8'h99);
    start_frame();
    spi_byte(8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t5_miso_after_reset", r, 8'h99);
    end_frame();

    // load in the exact boundary-reload cycle
    load(8'h22);
    start_frame();
    spi_byte(8'hA1, 1'b1, 8'h11, 1'b1, 8'h66, r, s);
    chk("t6_miso_byte0", r, 8'h22);
    chk("t6_tx_empty_between", tx_empty, 1'b0);
    spi_byte(8'hB2, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t6_miso_old_hold", r, 8'h11);
    spi_byte(8'hC4, 1'b0, 8'h00, 1'b0, 8'h00, r, s);
    chk("t6_miso_new_hold", r, 8'h66);
    end_frame();

    chk("rxq_drained", rxq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
